// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: request handshake, CSR image, TLB ports and completion signals
// of tlb_op_ctrl. The master side is the requester/TLB/CSR environment.
interface tlb_op_ctrl_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_vppn;

  logic [31:0]   csr_idx;
  logic [18:0]   csr_ehi_vppn;
  logic [9:0]    csr_asid;
  logic [5:0]    csr_ecode;
  logic [31:0]   csr_elo0;
  logic [31:0]   csr_elo1;

  logic          tlb_we;
  logic [IW-1:0] tlb_w_index;
  logic [88:0]   tlb_w_pkt;
  logic [IW-1:0] tlb_r_index;
  logic [88:0]   tlb_r_pkt;
  logic [18:0]   tlb_s_vppn;
  logic [9:0]    tlb_s_asid;
  logic          tlb_s_found;
  logic [IW-1:0] tlb_s_index;
  logic          invtlb_valid;
  logic [4:0]    invtlb_op;

  logic          csr_we;
  logic [3:0]    csr_wmask;
  logic [31:0]   csr_idx_wdata;
  logic [18:0]   csr_ehi_wdata;
  logic [9:0]    csr_asid_wdata;
  logic [31:0]   csr_elo0_wdata;
  logic [31:0]   csr_elo1_wdata;

  logic          done;
  logic          err;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vppn,
    output csr_idx, csr_ehi_vppn, csr_asid, csr_ecode, csr_elo0, csr_elo1,
    output tlb_r_pkt, tlb_s_found, tlb_s_index,
    input  op_ready, tlb_we, tlb_w_index, tlb_w_pkt, tlb_r_index,
    input  tlb_s_vppn, tlb_s_asid, invtlb_valid, invtlb_op,
    input  csr_we, csr_wmask, csr_idx_wdata, csr_ehi_wdata, csr_asid_wdata,
    input  csr_elo0_wdata, csr_elo1_wdata, done, err
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
    input  csr_idx, csr_ehi_vppn, csr_asid, csr_ecode, csr_elo0, csr_elo1,
    input  tlb_r_pkt, tlb_s_found, tlb_s_index,
    output op_ready, tlb_we, tlb_w_index, tlb_w_pkt, tlb_r_index,
    output tlb_s_vppn, tlb_s_asid, invtlb_valid, invtlb_op,
    output csr_we, csr_wmask, csr_idx_wdata, csr_ehi_wdata, csr_asid_wdata,
    output csr_elo0_wdata, csr_elo1_wdata, done, err
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB as IDLE->EXEC->RESP.
// Define TLB_FILL_RANDOM_EN for an LFSR fill index; default is a round-robin counter.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16
) (
  input  logic         clk,
  input  logic         resetn,
  tlb_op_ctrl_if.slave bus
);
  localparam int IW = $clog2(TLBNUM);
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_pkt_t;

  state_t        r_state, w_next;
  logic [2:0]    r_op;
  logic [4:0]    r_inv_op;
  logic [9:0]    r_inv_asid;
  logic [18:0]   r_inv_vppn;
  logic [31:0]   r_idx;
  logic [18:0]   r_ehi;
  logic [9:0]    r_asid;
  logic [5:0]    r_ecode;
  logic [31:0]   r_elo0, r_elo1;
  logic [IW-1:0] r_fill_idx;
  logic          r_found;
  logic [IW-1:0] r_s_index;
  tlb_pkt_t      r_rpkt;

  logic [IW-1:0] w_fill_src;
  tlb_pkt_t      w_wpkt;
  logic [31:0]   w_srch_idx, w_rd_idx, w_rd_elo0, w_rd_elo1;
  logic          w_unused;

  assign w_unused = ^{r_elo0[31:28], r_elo0[7], r_elo1[31:28], r_elo1[7]};

`ifdef TLB_FILL_RANDOM_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, free-running so the fill slot depends on issue timing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= 8'h01;
    else         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_fill_src = IW'(r_lfsr);
`else
  logic [IW-1:0] r_rr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_rr <= '0;
    else if (r_state == EXEC && r_op == OP_FILL)
      r_rr <= (r_rr == IW'(TLBNUM - 1)) ? '0 : r_rr + 1'b1;
  end
  assign w_fill_src = r_rr;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op       <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_idx      <= '0;
      r_ehi      <= '0;
      r_asid     <= '0;
      r_ecode    <= '0;
      r_elo0     <= '0;
      r_elo1     <= '0;
      r_fill_idx <= '0;
      r_found    <= 1'b0;
      r_s_index  <= '0;
      r_rpkt     <= '0;
    end else if (r_state == IDLE && bus.op_valid) begin
      r_op       <= bus.op_code;
      r_inv_op   <= bus.inv_op;
      r_inv_asid <= bus.inv_asid;
      r_inv_vppn <= bus.inv_vppn;
      r_idx      <= bus.csr_idx;
      r_ehi      <= bus.csr_ehi_vppn;
      r_asid     <= bus.csr_asid;
      r_ecode    <= bus.csr_ecode;
      r_elo0     <= bus.csr_elo0;
      r_elo1     <= bus.csr_elo1;
      r_fill_idx <= w_fill_src;
    end else if (r_state == EXEC) begin
      r_found    <= bus.tlb_s_found;
      r_s_index  <= bus.tlb_s_index;
      r_rpkt     <= bus.tlb_r_pkt;
    end
  end

  always_comb begin
    w_wpkt      = '0;
    w_wpkt.e    = (r_ecode == 6'h3F) ? 1'b1 : ~r_idx[31];
    w_wpkt.vppn = r_ehi;
    w_wpkt.ps   = r_idx[29:24];
    w_wpkt.asid = r_asid;
    w_wpkt.g    = r_elo0[6] & r_elo1[6];
    w_wpkt.ppn0 = r_elo0[27:8];
    w_wpkt.plv0 = r_elo0[3:2];
    w_wpkt.mat0 = r_elo0[5:4];
    w_wpkt.d0   = r_elo0[1];
    w_wpkt.v0   = r_elo0[0];
    w_wpkt.ppn1 = r_elo1[27:8];
    w_wpkt.plv1 = r_elo1[3:2];
    w_wpkt.mat1 = r_elo1[5:4];
    w_wpkt.d1   = r_elo1[1];
    w_wpkt.v1   = r_elo1[0];

    w_srch_idx = r_idx;
    if (r_found) begin
      w_srch_idx[IW-1:0] = r_s_index;
      w_srch_idx[31]     = 1'b0;
    end else begin
      w_srch_idx[31]     = 1'b1;
    end

    // an invalid entry reads back as ne=1 with every loaded field cleared
    w_rd_idx        = r_idx;
    w_rd_idx[31]    = ~r_rpkt.e;
    w_rd_idx[29:24] = r_rpkt.e ? r_rpkt.ps : 6'h00;
    w_rd_elo0 = '0;
    w_rd_elo1 = '0;
    if (r_rpkt.e) begin
      w_rd_elo0 = {4'h0, r_rpkt.ppn0, 1'b0, r_rpkt.g, r_rpkt.mat0, r_rpkt.plv0, r_rpkt.d0, r_rpkt.v0};
      w_rd_elo1 = {4'h0, r_rpkt.ppn1, 1'b0, r_rpkt.g, r_rpkt.mat1, r_rpkt.plv1, r_rpkt.d1, r_rpkt.v1};
    end
  end

  always_comb begin
    w_next             = r_state;
    bus.op_ready       = 1'b0;
    bus.tlb_we         = 1'b0;
    bus.tlb_w_index    = '0;
    bus.tlb_w_pkt      = '0;
    bus.tlb_r_index    = '0;
    bus.tlb_s_vppn     = '0;
    bus.tlb_s_asid     = '0;
    bus.invtlb_valid   = 1'b0;
    bus.invtlb_op      = '0;
    bus.csr_we         = 1'b0;
    bus.csr_wmask      = '0;
    bus.csr_idx_wdata  = '0;
    bus.csr_ehi_wdata  = '0;
    bus.csr_asid_wdata = '0;
    bus.csr_elo0_wdata = '0;
    bus.csr_elo1_wdata = '0;
    bus.done           = 1'b0;
    bus.err            = 1'b0;
    case (r_state)
      IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) w_next = EXEC;
      end
      EXEC: begin
        w_next = RESP;
        case (r_op)
          OP_SRCH: begin
            bus.tlb_s_vppn = r_ehi;
            bus.tlb_s_asid = r_asid;
          end
          OP_RD: bus.tlb_r_index = r_idx[IW-1:0];
          OP_WR, OP_FILL: begin
            bus.tlb_we      = 1'b1;
            bus.tlb_w_index = (r_op == OP_FILL) ? r_fill_idx : r_idx[IW-1:0];
            bus.tlb_w_pkt   = w_wpkt;
          end
          OP_INV: begin
            if (r_inv_op <= 5'd6) begin
              bus.invtlb_valid = 1'b1;
              bus.invtlb_op    = r_inv_op;
              bus.tlb_s_asid   = r_inv_asid;
              bus.tlb_s_vppn   = r_inv_vppn;
            end
          end
          default: ;
        endcase
      end
      RESP: begin
        w_next   = IDLE;
        bus.done = 1'b1;
        case (r_op)
          OP_SRCH: begin
            bus.csr_we        = 1'b1;
            bus.csr_wmask     = 4'b0001;
            bus.csr_idx_wdata = w_srch_idx;
          end
          OP_RD: begin
            bus.csr_we         = 1'b1;
            bus.csr_wmask      = 4'b1111;
            bus.csr_idx_wdata  = w_rd_idx;
            bus.csr_ehi_wdata  = r_rpkt.e ? r_rpkt.vppn : 19'h0;
            bus.csr_asid_wdata = r_rpkt.e ? r_rpkt.asid : 10'h0;
            bus.csr_elo0_wdata = w_rd_elo0;
            bus.csr_elo1_wdata = w_rd_elo1;
          end
          OP_WR, OP_FILL: ;
          OP_INV:  bus.err = (r_inv_op > 5'd6);
          default: bus.err = 1'b1;
        endcase
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; IW = clog2(TLBNUM).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 op_valid in 1 / op_ready out 1: request handshake; transfer when both are high on a clk edge.
REQ-005 op_code  in  3  0=TLBSRCH, 1=TLBRD, 2=TLBWR, 3=TLBFILL, 4=INVTLB, 5-7=reserved.
REQ-006 inv_op in 5, inv_asid in 10, inv_vppn in 19: INVTLB operands.
REQ-007 csr_idx in 32 (index[IW-1:0], ps[29:24], ne[31]); csr_ehi_vppn in 19; csr_asid in 10; csr_ecode in 6.
REQ-008 csr_elo0, csr_elo1  in  32 each  (v[0], d[1], plv[3:2], mat[5:4], g[6], ppn[27:8]).
REQ-009 tlb_we out 1, tlb_w_index out IW, tlb_w_pkt out 89: TLB write port.
REQ-010 Packet layout, MSB first: e, vppn[19], ps[6], asid[10], g, ppn0[20], plv0[2], mat0[2], d0, v0, ppn1[20], plv1[2], mat1[2], d1, v1.
REQ-011 tlb_r_index out IW, tlb_r_pkt in 89 (same layout): TLB read port.
REQ-012 tlb_s_vppn out 19, tlb_s_asid out 10, tlb_s_found in 1, tlb_s_index in IW: TLB search port.
REQ-013 invtlb_valid out 1, invtlb_op out 5: invalidate strobe to TLB; tlb_s_asid/tlb_s_vppn carry its operands.
REQ-014 csr_we out 1, csr_wmask out 4 (bit0 idx, bit1 ehi+asid, bit2 elo0, bit3 elo1), csr_idx_wdata 32, csr_ehi_wdata 19, csr_asid_wdata 10, csr_elo0_wdata 32, csr_elo1_wdata 32.
REQ-015 done out 1 one-cycle completion pulse; err out 1 valid with done.

Function
REQ-016 States IDLE, EXEC, RESP; op_ready=1 only in IDLE.
REQ-017 On accept, op_code, inv operands, all csr_* inputs and fill index are registered; IDLE->EXEC.
REQ-018 EXEC lasts exactly one cycle, then RESP; RESP asserts done for one cycle, then IDLE; accept-to-done = 2 cycles, next accept earliest the cycle after done.
REQ-019 TLBSRCH: EXEC drives tlb_s_vppn=ehi_vppn, tlb_s_asid=asid, samples found/index; RESP csr_we=1, wmask=0001; hit: index=tlb_s_index, ne=0; miss: index unchanged, ne=1; ps field unchanged.
REQ-020 TLBRD: EXEC drives tlb_r_index=idx.index, samples tlb_r_pkt; e=1: idx.ps=ps, ne=0, ehi/asid/elo0/elo1 loaded, elo g bits=pkt g; e=0: ne=1, ps=0, ehi, asid, elo0, elo1 all 0; wmask=1111.
REQ-021 TLBWR: EXEC pulses tlb_we one cycle, index=idx.index; e = ecode==6'h3F ? 1 : ~ne; g = elo0.g & elo1.g; other fields from captured CSRs; csr_we=0.
REQ-022 TLBFILL: as TLBWR except index = captured fill index.
REQ-023 INVTLB: inv_op<=6: EXEC pulses invtlb_valid, invtlb_op=inv_op, s port=inv operands; inv_op>6: no pulse, err=1.
REQ-024 Reserved op_code: no TLB or CSR action, done with err=1.
REQ-025 Outside EXEC, tlb_we and invtlb_valid are 0; outside RESP, done, err and csr_we are 0.
REQ-026 tlb_we and invtlb_valid are never high in the same cycle.

Reset
REQ-027 resetn low forces IDLE at once, even mid-operation; all strobes, done, err, wmask and data outputs 0; fill-index generator to seed.

Configuration
REQ-028 TLB_FILL_RANDOM_EN defined: fill index = low IW bits of an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01) stepping every clk.
REQ-029 TLB_FILL_RANDOM_EN undefined: fill index = IW-bit round-robin counter, reset 0, incremented after each TLBFILL, wrapping TLBNUM-1->0.

Verification
REQ-030 TLBSRCH, tlb_s_found=1, s_index=5 -> done at cycle 2, csr_we, wmask=0001, idx.index=5, ne=0.
REQ-031 TLBRD index 3, pkt e=0 -> ne=1, ps=0, ehi/asid/elo0/elo1=0, wmask=1111.
REQ-032 TLBWR, ne=1, ecode=6'h3F -> one-cycle tlb_we, e=1; repeat with ecode=0 -> e=0.
REQ-033 Round-robin build: 17 TLBFILLs (TLBNUM=16) -> indices 0..15 then 0.
REQ-034 INVTLB op=7 -> no invtlb_valid, err=1; op=5 -> one invtlb_valid pulse, err=0.
REQ-035 resetn low during EXEC of TLBWR -> tlb_we drops at once, no done, op_ready=1 after release.
